uart_pipe_router: RTL and testbench
===================================

Name: uart_pipe_router

Overview:
- Pipe-mode dispatcher between the SPI slave and the bank of per-module UART TX/RX instances.
- Each 16-bit SPI word {module_id[15:8], code[7:0]} is decoded and the code is sent to the selected module's UART.
- It then waits, with a timeout, for that module's one-byte reply and returns a 16-bit status/data word for the next SPI transfer.
- Only one transaction is in flight at a time; words arriving while busy are dropped and counted.

Parameters:
NUM_MODULES, 9, number of UART channels; valid ids are 0..NUM_MODULES-1
TIMEOUT_CYCLES, 48000, clk cycles (1 ms at 48 MHz) allowed in WAIT_TX and in WAIT_RX, each counted separately
ID_W, 8, width of the module_id field (fixed to 8 by the word format)

Ports:
clk  input  1  system clock (48 MHz HFOSC)
reset  input  1  asynchronous, active-high reset
spi_valid  input  1  one-cycle pulse; spi_word is valid in that cycle (SPI transfer_done)
spi_word  input  16  {module_id, code}
resp_valid  output  1  one-cycle pulse when resp_word is updated
resp_word  output  16  {status[7:0], data[7:0]}; held until the next update
start_tx  output  NUM_MODULES  one-hot, one-cycle start pulse to the selected UART TX
tx_data  output  8  byte for UART TX, broadcast to all channels
tx_busy  input  NUM_MODULES  per-channel UART TX busy
rx_done  input  NUM_MODULES  per-channel one-cycle byte-received pulse
rx_data  input  8*NUM_MODULES  flattened received bytes; channel k occupies bits [8k+7:8k]
parity_error  input  NUM_MODULES  per-channel parity flag, valid together with rx_done
busy  output  1  high whenever state != IDLE
drop_cnt  output  8  saturating count of spi_valid pulses ignored while busy

Behaviour:
- Reset (async, active-high): state=IDLE; start_tx=0, tx_data=0, resp_valid=0, resp_word=0, busy=0, drop_cnt=0, timeout counter=0.
  - Reset asserted mid-transaction aborts it; no response is produced.
- FSM states: IDLE, DECODE, WAIT_TX, SEND, WAIT_RX, RESPOND.
- IDLE:
  - spi_valid=1 latches id=spi_word[15:8] and code=spi_word[7:0]; next state DECODE.
- DECODE:
  - id >= NUM_MODULES: status=0xE1, data=0x00; go to RESPOND. No UART is touched.
  - Otherwise: tx_data<=code, clear the counter, go to WAIT_TX.
- WAIT_TX:
  - tx_busy[id]=0: go to SEND.
  - Counter reaches TIMEOUT_CYCLES-1 first: status=0xE4, data=code; go to RESPOND.
  - rx_done on any channel is ignored here, which flushes stale bytes.
- SEND:
  - start_tx[id]=1 for exactly this cycle; clear the counter; go to WAIT_RX.
  - tx_data stays stable from DECODE until the router returns to IDLE.
- WAIT_RX:
  - rx_done[id]=1 with parity_error[id]=0: status=0x00, data=rx_data[id].
  - rx_done[id]=1 with parity_error[id]=1: status=0xE2, data=rx_data[id].
  - Counter reaches TIMEOUT_CYCLES-1: status=0xE3, data=0x00.
  - If rx_done[id] and the timeout expiry fall in the same cycle, rx_done wins.
  - rx_done on any other channel is ignored.
  - Every exit from WAIT_RX goes to RESPOND.
- RESPOND:
  - resp_word<={status,data} and resp_valid=1 for one cycle; next state IDLE.
- Latency:
  - Bad id: resp_valid is high 3 cycles after the spi_valid cycle (cycle N+3).
  - Good id, idle TX: start_tx is high at N+3 (IDLE accept N, DECODE N+1, WAIT_TX N+2, SEND N+3).
  - Response: resp_valid is high 2 cycles after rx_done (WAIT_RX sees rx_done, then RESPOND).
- spi_valid while busy=1:
  - The word is dropped and drop_cnt increments, saturating at 0xFF.
  - spi_valid in the RESPOND cycle is also dropped; the router accepts again only in IDLE.
- Counter width is $clog2(TIMEOUT_CYCLES); it never wraps and is cleared on entry to WAIT_TX and WAIT_RX.
- start_tx is never multi-hot and never asserted outside SEND.

Test Plan:
- spi_word=0x0355, tx_busy=0, module 3 replies 0xA7 on rx_done[3] -> start_tx=0b000001000 for one cycle with tx_data=0x55; resp_word=0x00A7; one resp_valid pulse; busy returns to 0.
- spi_word=0x0C12 (id 12 >= 9) -> resp_word=0xE100 at N+3; start_tx stays 0.
- spi_word=0x0001, no reply, TIMEOUT_CYCLES=100 -> resp_word=0xE300 exactly 100 cycles after SEND plus RESPOND; an rx_done[1] arriving afterwards is ignored.
- tx_busy[2] held 1 for 10 cycles, then spi_word=0x0277 -> start_tx[2] pulses on the cycle after tx_busy[2] falls; tx_busy[2] held forever -> resp_word=0xE477.
- rx_done[5]=1 with parity_error[5]=1 and rx_data[5]=0x3C -> resp_word=0xE23C. Additionally: rx_done[4] during a wait on id 5 is ignored; rx_done[5] in the same cycle as the timeout expiry gives status 0x00.
- Three spi_valid pulses during one transaction -> drop_cnt=3, one response only. Additionally: reset pulse in WAIT_RX -> all outputs are 0 immediately, there is no resp_valid, and the next word is accepted normally.

Source files
------------

// File: rtl/uart_pipe_router.sv
// uart_pipe_router: pipe-mode dispatcher between the SPI slave and the UART bank.
// Each SPI word {module_id, code} sends code to one UART channel, waits (with
// timeout) for that channel's one-byte reply and returns {status, data}.
//
// Handshake: spi_valid is a one-cycle pulse with spi_word valid in that cycle;
// there is no ready. A word is taken only while the router is IDLE, otherwise it
// is dropped and counted in drop_cnt. resp_valid is a one-cycle pulse marking a
// new resp_word, which then holds until the next pulse.
module uart_pipe_router #(
  parameter int NUM_MODULES    = 9,
  parameter int TIMEOUT_CYCLES = 48000,
  parameter int ID_W           = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     spi_valid,
  input  logic [15:0]              spi_word,
  output logic                     resp_valid,
  output logic [15:0]              resp_word,
  output logic [NUM_MODULES-1:0]   start_tx,
  output logic [7:0]               tx_data,
  input  logic [NUM_MODULES-1:0]   tx_busy,
  input  logic [NUM_MODULES-1:0]   rx_done,
  input  logic [8*NUM_MODULES-1:0] rx_data,
  input  logic [NUM_MODULES-1:0]   parity_error,
  output logic                     busy,
  output logic [7:0]               drop_cnt,
  output logic [2:0]               state_dbg
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int SEL_W = (NUM_MODULES > 1) ? $clog2(NUM_MODULES) : 1;
  localparam logic [ID_W-1:0]  NUM_ID   = ID_W'(NUM_MODULES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DECODE  = 3'd1,
    WAIT_TX = 3'd2,
    SEND    = 3'd3,
    WAIT_RX = 3'd4,
    RESPOND = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   id_q;
  logic [7:0]        code_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [15:0]       pend_q, pend_d;
  logic              pend_load, cnt_clr, cnt_inc, tx_load;
  logic [SEL_W-1:0]  sel;
  logic              sel_busy, sel_done, sel_perr;
  logic [7:0]        sel_byte;
  logic              cnt_last;

  assign sel       = id_q[SEL_W-1:0];
  assign cnt_last  = (cnt_q == CNT_LAST);
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

  // Per-channel mux for the selected module, plus the one-hot start pulse in SEND.
  always_comb begin
    sel_busy = 1'b0;
    sel_done = 1'b0;
    sel_perr = 1'b0;
    sel_byte = 8'h00;
    start_tx = '0;
    for (int k = 0; k < NUM_MODULES; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_busy    = tx_busy[k];
        sel_done    = rx_done[k];
        sel_perr    = parity_error[k];
        sel_byte    = rx_data[8*k +: 8];
        start_tx[k] = (state_q == SEND);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and control decode; rx_done wins over a simultaneous timeout.
  always_comb begin
    state_d   = state_q;
    pend_load = 1'b0;
    pend_d    = 16'h0000;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    tx_load   = 1'b0;
    case (state_q)
      IDLE: begin
        if (spi_valid) state_d = DECODE;
      end
      DECODE: begin
        if (id_q >= NUM_ID) begin
          pend_load = 1'b1;
          pend_d    = 16'hE100;
          state_d   = RESPOND;
        end else begin
          tx_load = 1'b1;
          cnt_clr = 1'b1;
          state_d = WAIT_TX;
        end
      end
      WAIT_TX: begin
        if (!sel_busy) begin
          state_d = SEND;
        end else if (cnt_last) begin
          pend_load = 1'b1;
          pend_d    = {8'hE4, code_q};
          state_d   = RESPOND;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      SEND: begin
        cnt_clr = 1'b1;
        state_d = WAIT_RX;
      end
      WAIT_RX: begin
        if (sel_done) begin
          pend_load = 1'b1;
          pend_d    = {(sel_perr ? 8'hE2 : 8'h00), sel_byte};
          state_d   = RESPOND;
        end else if (cnt_last) begin
          pend_load = 1'b1;
          pend_d    = 16'hE300;
          state_d   = RESPOND;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: request latch, TX byte, timeout counter, pending response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_q    <= '0;
      code_q  <= 8'h00;
      tx_data <= 8'h00;
      cnt_q   <= '0;
      pend_q  <= 16'h0000;
    end else begin
      if (state_q == IDLE && spi_valid) begin
        id_q   <= spi_word[15:8];
        code_q <= spi_word[7:0];
      end
      if (tx_load) tx_data <= code_q;
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + 1'b1;
      if (pend_load) pend_q <= pend_d;
    end
  end

  // Response register: one pulse per transaction, word held afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_word  <= 16'h0000;
    end else begin
      resp_valid <= (state_q == RESPOND);
      if (state_q == RESPOND) resp_word <= pend_q;
    end
  end

  // Saturating count of words that arrived while a transaction was in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt <= 8'h00;
    end else if (spi_valid && state_q != IDLE && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_pipe_router.sv
// Testbench for uart_pipe_router: randomized transactions against a timing and
// response model derived from the router's cycle rules, plus directed cases.
module tb_uart_pipe_router;

  localparam int NM = 9;
  localparam int T  = 100;

  logic              clk;
  logic              reset;
  logic              spi_valid;
  logic [15:0]       spi_word;
  logic              resp_valid;
  logic [15:0]       resp_word;
  logic [NM-1:0]     start_tx;
  logic [7:0]        tx_data;
  logic [NM-1:0]     tx_busy;
  logic [NM-1:0]     rx_done;
  logic [8*NM-1:0]   rx_data;
  logic [NM-1:0]     parity_error;
  logic              busy;
  logic [7:0]        drop_cnt;
  logic [2:0]        state_dbg;

  int total = 0;
  int bad   = 0;
  int exp_drops = 0;
  logic [15:0] exp_q[$];

  uart_pipe_router #(
    .NUM_MODULES(NM),
    .TIMEOUT_CYCLES(T),
    .ID_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .spi_valid(spi_valid),
    .spi_word(spi_word),
    .resp_valid(resp_valid),
    .resp_word(resp_word),
    .start_tx(start_tx),
    .tx_data(tx_data),
    .tx_busy(tx_busy),
    .rx_done(rx_done),
    .rx_data(rx_data),
    .parity_error(parity_error),
    .busy(busy),
    .drop_cnt(drop_cnt),
    .state_dbg(state_dbg)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_idle();
    spi_valid    = 1'b0;
    spi_word     = 16'h0000;
    tx_busy      = '0;
    rx_done      = '0;
    parity_error = '0;
    rx_data      = '0;
  endtask

  // Background noise on every channel; only the selected channel matters.
  task automatic drive_noise();
    for (int c = 0; c < NM; c++) rx_data[8*c +: 8] = 8'($urandom);
    parity_error = NM'($urandom);
    tx_busy      = NM'($urandom);
    rx_done      = '0;
    spi_valid    = 1'b0;
  endtask

  // One transaction. Cycle k is relative to the spi_valid cycle (k=0).
  // busy_len: tx_busy[id] is high for k < busy_len.
  // rx_off:   reply on rx_done[id] at start cycle + rx_off (negative = none).
  // drop_mode: 0 none, 1 three extra words, 2 an extra word every busy cycle.
  task automatic run_txn(input int id, input logic [7:0] code, input int busy_len,
                         input int rx_off, input bit perr, input logic [7:0] rbyte,
                         input int drop_mode);
    bit          good, has_start;
    int          s_rel, r_rel, freec, fid, mid;
    logic [15:0] exp_w;
    logic [NM-1:0] exp_st;
    good      = (id < NM);
    has_start = 1'b0;
    s_rel     = -10;
    fid       = (id == 0) ? 1 : id - 1;
    if (!good) begin
      r_rel = 3;
      exp_w = 16'hE100;
    end else begin
      // WAIT_TX occupies k=2..T+1; the first free cycle there moves to SEND.
      freec = (busy_len > 2) ? busy_len : 2;
      if (freec <= T + 1) begin
        has_start = 1'b1;
        s_rel = freec + 1;
        // WAIT_RX occupies s_rel+1 .. s_rel+T.
        if (rx_off >= 1 && rx_off <= T) begin
          r_rel = s_rel + rx_off + 2;
          exp_w = {(perr ? 8'hE2 : 8'h00), rbyte};
        end else begin
          r_rel = s_rel + T + 2;
          exp_w = 16'hE300;
        end
      end else begin
        r_rel = T + 3;
        exp_w = {8'hE4, code};
      end
    end
    exp_q.push_back(exp_w);
    mid = r_rel / 2;
    for (int k = 0; k <= r_rel + 1; k++) begin
      @(negedge clk);
      exp_st = '0;
      if (has_start && k == s_rel) exp_st[id] = 1'b1;
      check("start_tx", start_tx, exp_st);
      check("busy", busy, (k >= 1 && k < r_rel));
      check("resp_valid", resp_valid, (k == r_rel));
      if (resp_valid) begin
        if (exp_q.size() == 0) check("resp_extra", resp_valid, 1'b0);
        else check("resp_word", resp_word, exp_q.pop_front());
      end
      if (has_start && k == s_rel) check("tx_data", tx_data, code);
      if (k == r_rel + 1) check("drop_cnt", drop_cnt, exp_drops);
      drive_noise();
      if (k == 0) begin
        spi_valid = 1'b1;
        spi_word  = {id[7:0], code};
      end else if (k < r_rel && (drop_mode == 2 ||
                 (drop_mode == 1 && (k == 1 || k == mid || k == r_rel - 1)))) begin
        spi_valid = 1'b1;
        spi_word  = 16'($urandom);
        if (exp_drops < 255) exp_drops++;
      end
      if (good) begin
        tx_busy[id] = (k < busy_len);
        if (k == 2) rx_done[id] = 1'b1;              // stale byte during WAIT_TX
        if (has_start && k == s_rel + 1) rx_done[fid] = 1'b1;  // other channel
        if (has_start && rx_off >= 0 && k == s_rel + rx_off) begin
          rx_done[id]        = 1'b1;
          parity_error[id]   = perr;
          rx_data[8*id +: 8] = rbyte;
        end
      end
    end
    drive_idle();
  endtask

  initial begin
    bit saw;
    reset = 1'b1;
    drive_idle();
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_word", resp_word, 16'h0000);
    check("rst_start_tx", start_tx, '0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_drop_cnt", drop_cnt, 8'h00);
    reset = 1'b0;

    // Directed cases.
    run_txn(3, 8'h55, 0, 5, 1'b0, 8'hA7, 0);       // 0x00A7
    run_txn(12, 8'h12, 0, -1, 1'b0, 8'h00, 0);     // bad id -> 0xE100
    run_txn(0, 8'h01, 0, T + 1, 1'b0, 8'h66, 0);   // timeout -> 0xE300, late reply ignored
    run_txn(2, 8'h77, 10, 4, 1'b0, 8'h99, 0);      // TX busy 10 cycles
    run_txn(2, 8'h77, 1000, -1, 1'b0, 8'h00, 0);   // TX stuck -> 0xE477
    run_txn(5, 8'h10, 0, 7, 1'b1, 8'h3C, 0);       // parity -> 0xE23C
    run_txn(5, 8'h20, 0, T, 1'b0, 8'hC3, 0);       // reply on expiry cycle wins
    run_txn(2, 8'h31, T + 1, 3, 1'b0, 8'h5E, 0);   // TX frees on last WAIT_TX cycle
    run_txn(2, 8'h32, T + 2, 3, 1'b0, 8'h5E, 0);   // TX frees one cycle too late
    run_txn(4, 8'h44, 0, 10, 1'b0, 8'h81, 1);      // three dropped words

    // Reset in the middle of WAIT_RX aborts without a response.
    @(negedge clk);
    spi_valid = 1'b1;
    spi_word  = 16'h0501;
    @(negedge clk);
    spi_valid = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_start_tx", start_tx, '0);
    check("midrst_tx_data", tx_data, 8'h00);
    check("midrst_resp_word", resp_word, 16'h0000);
    check("midrst_resp_valid", resp_valid, 1'b0);
    check("midrst_drop_cnt", drop_cnt, 8'h00);
    exp_drops = 0;
    @(negedge clk);
    reset = 1'b0;
    saw = 1'b0;
    repeat (T + 20) begin
      @(negedge clk);
      if (resp_valid || busy) saw = 1'b1;
    end
    check("midrst_no_resp", saw, 1'b0);
    run_txn(5, 8'h0A, 0, 3, 1'b0, 8'hB2, 0);

    // Randomized transactions.
    for (int i = 0; i < 30; i++) begin
      int id, bl, ro, pick;
      id   = ($urandom_range(0, 5) == 0) ? $urandom_range(NM, 255) : $urandom_range(0, NM - 1);
      pick = $urandom_range(0, 9);
      bl   = (pick < 5) ? $urandom_range(0, 6) : (pick < 7) ? $urandom_range(7, 30) :
             (pick == 7) ? T + 1 : (pick == 8) ? T + 2 : 1000;
      pick = $urandom_range(0, 9);
      ro   = (pick < 6) ? $urandom_range(1, 20) : (pick == 6) ? $urandom_range(1, T) :
             (pick == 7) ? T : (pick == 8) ? T + 1 : -1;
      run_txn(id, 8'($urandom), bl, ro, 1'($urandom), 8'($urandom), $urandom_range(0, 1));
    end

    // Drop counter saturation.
    for (int i = 0; i < 3; i++) run_txn(0, 8'h5A, 0, -1, 1'b0, 8'h00, 2);
    check("drop_sat", drop_cnt, 8'hFF);

    check("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
